// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner selection for a shared 4:1 single-bit mux.
// It grants one requester at a time, drives the 2-bit mux select, and registers
// the selected data bit together with a valid strobe.
// Optional feature macro: MUX4_ARB_TIMEOUT_EN. When it is defined, an owner is
// forced to release after HOLD_MAX consecutive grant cycles. Without it, the
// owner keeps the grant until its request drops.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] i,
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic       y,
  output logic       valid,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state, state_nxt;
  logic [3:0] gnt_nxt;
  logic [1:0] s_nxt;
  logic       y_nxt;
  logic       valid_nxt;
  logic       busy_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic [1:0] arb_base;
  logic [2:0] pick;
  logic       expire;

  // Rotating priority search: returns {found, index}. Bit k of the rotated
  // vector is req[(base + k) mod 4], so the lowest set rotated bit wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [2:0] res;
    dbl = {r, r} >> base;
    rot = dbl[3:0];
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) res = {1'b1, base + 2'(k)};
    end
    return res;
  endfunction

`ifdef MUX4_ARB_TIMEOUT_EN
  assign expire = (hold_cnt == HOLD_LAST);
`else
  // The hold limit is never enforced in this build, so the compare is tied off.
  assign expire = 1'b0 & (hold_cnt == HOLD_LAST);
`endif

  // When idle, the search starts at ptr. While granting, a release moves ptr to
  // owner+1, so the search for the next owner starts from there on the same edge.
  assign arb_base = (state == GRANT) ? (s + 2'd1) : ptr;
  assign pick     = rr_pick(req, arb_base);

  // Register all state and outputs. Reset drops everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      s        <= 2'b00;
      y        <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      ptr      <= 2'd0;
      hold_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      s        <= s_nxt;
      y        <= y_nxt;
      valid    <= valid_nxt;
      busy     <= busy_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next-state logic: grant from idle, serve the owner, or release and
  // re-arbitrate on the same edge without an idle bubble.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    s_nxt     = s;
    y_nxt     = y;
    valid_nxt = 1'b0;
    busy_nxt  = busy;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (pick[2]) begin
          gnt_nxt   = 4'b0001 << pick[1:0];
          s_nxt     = pick[1:0];
          busy_nxt  = 1'b1;
          hold_nxt  = 8'd0;
          state_nxt = GRANT;
        end else begin
          gnt_nxt  = 4'b0000;
          busy_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (req[s] && !expire) begin
          y_nxt     = i[s];
          valid_nxt = 1'b1;
          if (hold_cnt != 8'hFF) hold_nxt = hold_cnt + 8'd1;
        end else begin
          ptr_nxt = s + 2'd1;
          if (pick[2]) begin
            gnt_nxt  = 4'b0001 << pick[1:0];
            s_nxt    = pick[1:0];
            busy_nxt = 1'b1;
            hold_nxt = 8'd0;
          end else begin
            gnt_nxt   = 4'b0000;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
